// File: rtl/mult_seq_ctrl.sv
// Operand-select sequencer and result capture for the mux -> SIPO -> Wallace multiplier.
// Optional saturating product accumulator is built only when MULT_ACC_EN is defined.
module mult_seq_ctrl #(
    parameter int unsigned ACC_W = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             acc_clr,
    input  logic [7:0]       y,
    output logic             sel0,
    output logic             sel1,
    output logic             sel2,
    output logic             sel3,
    output logic             busy,
    output logic             done,
    output logic [7:0]       product,
    output logic [ACC_W-1:0] acc
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SHIFT   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;

    logic [1:0] r_state;
    logic [1:0] r_cnt;
    logic       r_done;
    logic [7:0] r_product;
    logic [1:0] w_idx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_SHIFT;
                        r_cnt   <= '0;
                    end
                end
                S_SHIFT: begin
                    // cnt wraps back to 0 on the last shift, ready for the next op
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    r_product <= y;
                    r_done    <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_idx = '0;
        if (r_state == S_SHIFT) begin
            w_idx = r_cnt;
        end
    end

    always_comb begin
        sel0    = w_idx[0];
        sel1    = w_idx[1];
        sel2    = w_idx[0];
        sel3    = w_idx[1];
        busy    = (r_state == S_SHIFT) || (r_state == S_CAPTURE);
        done    = r_done;
        product = r_product;
    end

`ifdef MULT_ACC_EN
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W:0]   w_sum;

    always_comb begin
        w_sum = {1'b0, r_acc} + (ACC_W+1)'(y);
    end

    // Clear takes priority over a same-edge capture
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
        end else if (acc_clr) begin
            r_acc <= '0;
        end else if (r_state == S_CAPTURE) begin
            r_acc <= w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
        end
    end

    always_comb begin
        acc = r_acc;
    end
`else
    logic w_unused_acc_clr;

    always_comb begin
        w_unused_acc_clr = acc_clr;
        acc              = '0;
    end
`endif

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl with a behavioural mux/SIPO/multiplier stand-in.
// Accumulator checks are compiled in when MULT_ACC_EN is defined.
module tb_mult_seq_ctrl;

    localparam int unsigned ACC_W = 10;
    localparam int ACC_MAX = (1 << ACC_W) - 1;

    logic             clock;
    logic             reset;
    logic             start;
    logic             acc_clr;
    logic [7:0]       y;
    logic             sel0, sel1, sel2, sel3;
    logic             busy;
    logic             done;
    logic [7:0]       product;
    logic [ACC_W-1:0] acc;

    mult_seq_ctrl #(.ACC_W(ACC_W)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .acc_clr (acc_clr),
        .y       (y),
        .sel0    (sel0),
        .sel1    (sel1),
        .sel2    (sel2),
        .sel3    (sel3),
        .busy    (busy),
        .done    (done),
        .product (product),
        .acc     (acc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Datapath stand-in: bit-select mux, LSB-first SIPO (first bit ends in q[0]), multiplier
    logic [3:0] a_op, b_op, sipo_a, sipo_b;
    always @(posedge clock) begin
        sipo_a <= {a_op[{sel1, sel0}], sipo_a[3:1]};
        sipo_b <= {b_op[{sel3, sel2}], sipo_b[3:1]};
    end
    assign y = 8'(sipo_a) * 8'(sipo_b);

    int n_checks = 0;
    int n_errors = 0;
    int acc_m    = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        int         exp_p;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic int acc_add(input int cur, input int p);
        int s;
        s = cur + p;
        if (s > ACC_MAX) s = ACC_MAX;
        return s;
    endfunction

    function automatic logic [31:0] sel_vec;
        return {28'd0, sel3, sel2, sel1, sel0};
    endfunction

    // One full operation from start acceptance through the done pulse
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input int exp_p, input logic clr);
        a_op  = a;
        b_op  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("shift_sel", sel_vec(), 32'((k << 2) | k));
            check("shift_busy", 32'(busy), 32'd1);
            check("shift_done", 32'(done), 32'd0);
            tick();
        end
        check("capture_busy", 32'(busy), 32'd1);
        check("capture_sel", sel_vec(), 32'd0);
        check("capture_done", 32'(done), 32'd0);
        acc_clr = clr;
        tick();
        acc_clr = 1'b0;
`ifdef MULT_ACC_EN
        acc_m = clr ? 0 : acc_add(acc_m, exp_p);
`endif
        check("done_pulse", 32'(done), 32'd1);
        check("product", 32'(product), 32'(exp_p));
        check("idle_busy", 32'(busy), 32'd0);
        check("acc", 32'(acc), 32'(acc_m));
        tick();
        check("done_clear", 32'(done), 32'd0);
        check("product_hold", 32'(product), 32'(exp_p));
    endtask

    initial begin
        vecs[0] = '{a: 4'b1011, b: 4'b0110, exp_p: 66};
        vecs[1] = '{a: 4'hF,    b: 4'hF,    exp_p: 225};
        vecs[2] = '{a: 4'd3,    b: 4'd5,    exp_p: 15};
        vecs[3] = '{a: 4'd0,    b: 4'd9,    exp_p: 0};
        vecs[4] = '{a: 4'd1,    b: 4'd1,    exp_p: 1};
        vecs[5] = '{a: 4'd8,    b: 4'd8,    exp_p: 64};
        vecs[6] = '{a: 4'd7,    b: 4'd9,    exp_p: 63};
        vecs[7] = '{a: 4'd12,   b: 4'd10,   exp_p: 120};

        reset   = 1'b0;
        start   = 1'b0;
        acc_clr = 1'b0;
        a_op    = '0;
        b_op    = '0;
        #1 reset = 1'b1;
        #1;
        check("reset_sel", sel_vec(), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_product", 32'(product), 32'd0);
        check("reset_acc", 32'(acc), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("idle_sel", sel_vec(), 32'd0);
        check("idle_busy0", 32'(busy), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp_p, 1'b0);
        end

        for (int i = 0; i < 20; i++) begin
            logic [3:0] ra, rb;
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            run_op(ra, rb, int'(ra) * int'(rb), 1'b0);
        end

        // start held high for 14 cycles: accepted at ticks 1, 7, 13
        a_op  = 4'hF;
        b_op  = 4'hF;
        start = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (t == 14) start = 1'b0;
            check("held_done", 32'(done), 32'((t == 6) || (t == 12) || (t == 18)));
            if (t == 6 || t == 12 || t == 18) begin
                check("held_product", 32'(product), 32'd225);
`ifdef MULT_ACC_EN
                acc_m = acc_add(acc_m, 225);
`endif
            end
            if (t == 12) check("held_idle_gap", 32'(busy), 32'd0);
            if (t == 13) check("held_third_accept", 32'(busy), 32'd1);
        end
        check("held_acc", 32'(acc), 32'(acc_m));

        // start re-pulsed during SHIFT must be ignored
        a_op  = 4'b1011;
        b_op  = 4'b0110;
        start = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            start = (t == 2);
            if (t <= 4) check("ignore_sel", sel_vec(), 32'(((t - 1) << 2) | (t - 1)));
            check("ignore_done", 32'(done), 32'(t == 6));
            check("ignore_busy", 32'(busy), 32'(t <= 5));
        end
        check("ignore_product", 32'(product), 32'd66);
`ifdef MULT_ACC_EN
        acc_m = acc_add(acc_m, 66);
`endif
        check("ignore_acc", 32'(acc), 32'(acc_m));

        // reset mid-SHIFT at cnt = 2
        a_op  = 4'd9;
        b_op  = 4'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pre_reset_sel", sel_vec(), 32'd10);
        #2 reset = 1'b1;
        #1;
        acc_m = 0;
        check("abort_sel", sel_vec(), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        check("abort_acc", 32'(acc), 32'd0);
        tick();
        reset = 1'b0;
        for (int t = 0; t < 6; t++) begin
            tick();
            check("post_reset_done", 32'(done), 32'd0);
            check("post_reset_busy", 32'(busy), 32'd0);
        end
        run_op(4'd3, 4'd5, 15, 1'b0);

`ifdef MULT_ACC_EN
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        acc_m = 0;
        check("acc_clr_idle", 32'(acc), 32'd0);
        for (int i = 0; i < 3; i++) run_op(4'hF, 4'hF, 225, 1'b0);
        check("acc_three_ops", 32'(acc), 32'd675);
        for (int i = 0; i < 2; i++) run_op(4'hF, 4'hF, 225, 1'b0);
        check("acc_saturated", 32'(acc), 32'd1023);
        run_op(4'hF, 4'hF, 225, 1'b1);
        check("acc_clr_priority", 32'(acc), 32'd0);
        run_op(4'd2, 4'd3, 6, 1'b0);
        check("acc_after_clr", 32'(acc), 32'd6);
`else
        check("acc_tied_zero", 32'(acc), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

Sequencer that drives the operand-select lines of the mux → SIPO → Wallace multiplier datapath and captures its 8-bit result. On a `start` request it steps the select lines through bit indices 0..3 so that each 4-bit SIPO fills with the full operand, then registers the combinational product `Y` and pulses `done`. It sits directly upstream and downstream of the multiplier top: its `sel*` outputs feed the mux selects, and its `y` input consumes the product bus.

## Interface
- `ACC_W`, default 10: accumulator width. Used only with `MULT_ACC_EN`. Minimum 8.
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a multiply. Sampled only in IDLE.
- `acc_clr`  in  1  synchronous accumulator clear. Ignored without `MULT_ACC_EN`.
- `y`  in  8  combinational product from the Wallace multiplier.
- `sel0`, `sel1`  out  1 each  A-mux select; bit index = {sel1,sel0}.
- `sel2`, `sel3`  out  1 each  B-mux select; bit index = {sel3,sel2}.
- `busy`  out  1  high in SHIFT and CAPTURE.
- `done`  out  1  one-cycle pulse when `product` updates.
- `product`  out  8  registered result.
- `acc`  out  ACC_W  running sum of products; tied to 0 without `MULT_ACC_EN`.

## Operation
- FSM states:
  - IDLE: sel = 00/00, `busy` = 0. `start` = 1 → SHIFT, cnt = 0.
  - SHIFT: `{sel1,sel0}` = `{sel3,sel2}` = cnt, driven combinationally from the registered 2-bit `cnt`. Each edge increments `cnt`. On the edge where cnt = 3 → CAPTURE.
  - CAPTURE: `product` ← `y`, `done` ← 1, then → IDLE.
- Bit order is LSB first (index 0,1,2,3). The SIPO's first-in bit ends in q[0], so after 4 shifts the SIPOs hold A and B unchanged.
- `start` in SHIFT or CAPTURE is ignored. It is not queued.
- `product` holds its value until the next CAPTURE.
- Arithmetic: the operands are unsigned 4-bit, so `product` ≤ 225 and needs no truncation.
- The SIPOs have no reset. A `reset` mid-operation leaves stale SIPO bits, but the next full operation overwrites all 4 positions, so no stale data reaches `product`.

## Timing
- Edge E0 samples `start` = 1 in IDLE.
- Edges E1..E4 shift bits 0..3. `sel` shows index k during the cycle before edge E(k+1).
- `y` is valid during the cycle after E4. E5 registers `product`, and `done` is high from E5 to E6.
- Latency is 5 cycles from start acceptance to `done`.
- Minimum start-to-start period is 6 cycles: `start` held high re-accepts at E6.
- Reset values (asynchronous, immediate): state = IDLE, `cnt` = 0, all `sel` = 0, `busy` = 0, `done` = 0, `product` = 0, `acc` = 0.
- A reset asserted in any state aborts the operation. No `done` pulse occurs, and `product` is forced to 0.

## Configuration
- Macro `MULT_ACC_EN`.
- Defined:
  - At the CAPTURE edge, `acc` ← `acc` + `y`, saturating at 2^ACC_W−1.
  - `acc_clr` = 1 sets `acc` to 0 on the next edge.
  - If `acc_clr` and CAPTURE occur on the same edge, clear wins: `acc` = 0 and that product is not added.
- Undefined:
  - No accumulator register is built. `acc` is constant 0 and `acc_clr` is unused.

## Test plan
- A = 4'b1011, B = 4'b0110, single `start` pulse:
  - `sel` sequence is 00, 01, 10, 11.
  - `busy` is high for 5 cycles.
  - `done` pulses at E5.
  - `product` = 8'h42 (66).
- A = B = 4'hF with `start` held high for 14 cycles:
  - `done` pulses at E5 and E11.
  - `product` = 8'hE1 (225).
  - The `start` sampled at E12 is the third acceptance.
- `start` pulsed again during SHIFT (cycle 2):
  - The pulse is ignored.
  - Only one `done` is produced.
  - `cnt` proceeds 0→3 uninterrupted.
- `reset` asserted mid-SHIFT at cnt = 2, then released, then a new op with A = 3, B = 5:
  - All outputs are 0 immediately on reset.
  - The new op gives `product` = 15.
  - No spurious `done` occurs.
- `MULT_ACC_EN` accumulation and saturation (ACC_W = 10, A = B = 15):
  - After 3 ops, `acc` = 675.
  - After 5 ops, `acc` = 1023 (saturated).
- `MULT_ACC_EN` clear priority:
  - Assert `acc_clr` on the E5 edge of an op. Then `acc` = 0.
  - A following op with A = 2, B = 3 gives `acc` = 6.
